pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register that generalises the fixed IF/ID latch into a reusable stage boundary for any pair of adjacent CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of configurable width with a valid/ready handshake, a stall (hold) input and a flush (bubble-insert) input. An optional skid entry registers `in_ready`, so stall and back-pressure never form a combinational path to the upstream stage. Flushed or drained slots present a configurable NOP pattern downstream.

## Interface

- `DATA_W`, 68: payload width; the IF/ID use case is 32 (pc+4) + 32 (instruction) + 4 (pc high bits).
- `NOP_DATA`, 0: payload value shown on `out_data` whenever `out_valid=0`.
- `SKID`, 1: 1 = two-entry stage with registered `in_ready`; 0 = single entry with combinational `in_ready`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream consumes the beat.
- `out_data`  out  DATA_W  payload; equals `NOP_DATA` when `out_valid=0`.
- `stall`  in  1  hazard hold; blocks downstream consumption.
- `flush`  in  1  squash; empties the stage.
- `occ`  out  2  number of held beats (0–2).

## Operation

- in_fire = `in_valid & in_ready & ~flush`.
- out_fire = `out_valid & out_ready & ~stall`.
- State is held in a main register (drives `out_*`) and, when SKID=1, a skid register.
- SKID=1 occupancy FSM:
  - EMPTY (occ=0)
    - in_fire -> main<=in_data, ONE.
  - ONE (occ=1)
    - in_fire & out_fire -> main<=in_data, stay ONE.
    - in_fire only -> skid<=in_data, FULL.
    - out_fire only -> main<=NOP_DATA, EMPTY.
  - FULL (occ=2)
    - out_fire -> main<=skid, skid<=NOP_DATA, ONE.
    - `in_ready=0`, so no in_fire.
  - `in_ready` is a flop, set to 1 exactly when the next state is not FULL.
- SKID=0:
  - `in_ready = ~out_valid | out_fire` (combinational).
  - `occ` is 0 or 1.
  - Skid register is absent.
- Flush takes priority over all other events:
  - next cycle occ=0, `out_valid=0`, main and skid = NOP_DATA.
  - `in_ready=1` in the next cycle.
  - A beat offered in the flush cycle is dropped.
  - A beat downstream sees in the flush cycle is not consumed by this block's accounting.
- Stall with `out_ready=1`: no out_fire, and the payload is held bit-exact. Inputs are still accepted into a free slot (EMPTY, or ONE to FULL).
- Simultaneous stall and flush: flush wins.
- Payload is never modified. Width mismatch is not checked; ports are exactly DATA_W.

## Timing

- Reset (async assert, synchronous-style deassert handled by the system):
  - occ=0, `out_valid=0`, `out_data=NOP_DATA`, skid=NOP_DATA.
  - `in_ready=1` for SKID=1; 1 for SKID=0 via the combinational term.
- Reset asserted mid-operation discards all held beats immediately, without waiting for a clock.
- Latency: in_fire at edge N makes `out_valid=1` with that payload after edge N (visible in cycle N+1). There is no combinational in->out path.
- Throughput: 1 beat/cycle sustained when `out_ready=1` and `stall=0`, in both SKID modes.
- SKID=1 has no combinational path from `out_ready` or `stall` to `in_ready`.
- Ordering is strictly FIFO; no beat is duplicated or lost except by flush.

## Test plan

- Reset: drive `rst=0` mid-stream with occ=2 -> asynchronously `out_valid=0`, `out_data=0`, occ=0. After release, `in_ready=1`.
- Streaming: feed 0x1..0x10 back-to-back with `out_ready=1` -> `out_data` shows 0x1..0x10 one cycle later each cycle, occ stays 1, and `in_ready` stays 1.
- Stall fill (SKID=1): hold `stall=1` while sending 0xA, 0xB, 0xC -> 0xA held on `out_data`, occ=2, `in_ready=0`, 0xC not accepted. Release stall -> outputs 0xA, 0xB, 0xC in order.
- Flush priority: in FULL, assert `flush=1` with `stall=1` and `in_valid=1`, `in_data=0xD` -> next cycle occ=0, `out_valid=0`, `out_data=NOP_DATA`, and 0xD never appears.
- Back-pressure toggling: randomised `out_ready`/`in_valid` for 10k cycles, both SKID settings -> scoreboard shows an ordered, lossless stream, occ within its mode limit, and `in_ready` equal to the registered flop (SKID=1).
- NOP pattern: with `NOP_DATA=68'h0_0000_0000_0000_0013`, drain the stage -> `out_data` equals the pattern whenever `out_valid=0`.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: upstream handshake, downstream handshake and pipeline controls.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 68
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic              flush;
  logic [1:0]        occ;

  // Driving side: upstream producer, downstream consumer and hazard control together.
  modport master (
    output in_valid, in_data, out_ready, stall, flush,
    input  in_ready, out_valid, out_data, occ
  );

  // The stage register itself.
  modport slave (
    input  in_valid, in_data, out_ready, stall, flush,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with valid/ready handshake, stall, flush and an
// optional skid entry that makes in_ready a flop.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 68,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       SKID     = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;

  logic              out_valid;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;

  // Handshake qualifiers; flush suppresses acceptance, stall suppresses consumption.
  always_comb begin
    out_valid = (state_q != StEmpty);
    out_fire  = out_valid & bus.out_ready & ~bus.stall;
    in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_fire);
    in_fire   = bus.in_valid & in_ready & ~bus.flush;
  end

  // State register; reset discards held beats without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      main_q     <= NOP_DATA;
      skid_q     <= NOP_DATA;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state: occupancy transitions and payload movement, flush overriding all.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = StEmpty;
      main_d  = NOP_DATA;
      skid_d  = NOP_DATA;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = bus.in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            // Only reachable with a skid entry; without one in_ready implies out_fire here.
            if (SKID != 0) begin
              skid_d  = bus.in_data;
              state_d = StFull;
            end
          end else if (out_fire) begin
            main_d  = NOP_DATA;
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_DATA;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end
      endcase
    end
    // Registered ready: accept next cycle unless both entries will be occupied.
    in_ready_d = (state_d != StFull);
  end

  // Outputs: main entry drives downstream; it holds NOP_DATA whenever the stage is empty.
  always_comb begin
    bus.out_valid = out_valid;
    bus.out_data  = main_q;
    bus.in_ready  = in_ready;
    unique case (state_q)
      StEmpty: bus.occ = 2'd0;
      StOne:   bus.occ = 2'd1;
      StFull:  bus.occ = 2'd2;
      default: bus.occ = 2'd0;
    endcase
  end

endmodule
